// File: rtl/rx_arbiter_pkg.sv
// Shared constants for the router input-stage arbiter: channel indices,
// FSM state encoding and the channel index type.
package rx_pkg;

  localparam int NPORTS = 5;

  typedef logic [2:0] chan_t;

  localparam chan_t P_N = 3'd0;
  localparam chan_t P_S = 3'd1;
  localparam chan_t P_E = 3'd2;
  localparam chan_t P_W = 3'd3;
  localparam chan_t P_L = 3'd4;

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_LOCKED = 1'b1;

endpackage

// File: rtl/rx_arbiter_rr_pick5.sv
// Combinational five-way round-robin picker: the first requester after
// ptr wins, wrapping 4->0 and ending at ptr itself.
module rr_pick5
  import rx_pkg::*;
(
  input  logic [NPORTS-1:0] req,
  input  chan_t             ptr,
  output logic [NPORTS-1:0] gnt,
  output chan_t             gnt_idx
);

  logic  found;
  chan_t idx;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = '0;
    for (int k = 1; k <= NPORTS; k++) begin
      idx = chan_t'((int'(ptr) + k) % NPORTS);
      if (!found && req[idx]) begin
        found      = 1'b1;
        gnt[idx]   = 1'b1;
        gnt_idx    = idx;
      end
    end
  end

endmodule

// File: rtl/rx_arbiter.sv
// Packet-aware round-robin arbiter sharing one FIFO write port among five
// channels. Define RX_ARB_TIMEOUT_EN to add a forced release of idle owners.
module rx_arbiter
  import rx_pkg::*;
#(
  parameter int SIZE    = 8,
  parameter int TIMEOUT = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NPORTS-1:0]      in_valid,
  input  logic [NPORTS-1:0]      in_tail,
  input  logic [NPORTS*SIZE-1:0] in_item,
  output logic [NPORTS-1:0]      in_read,
  input  logic                   full,
  output logic                   write,
  output logic [SIZE-1:0]        item_out,
  output logic                   locked,
  output logic                   err_timeout
);

  logic [0:0]        fsm;
  chan_t             ptr;
  chan_t             owner;
  logic [NPORTS-1:0] gnt;
  chan_t             gnt_idx;
  chan_t             sel;
  logic              can;
  logic              xfer;
  logic              fire;

  rr_pick5 u_pick (
    .req     (in_valid),
    .ptr     (ptr),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

`ifdef RX_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt;

  assign fire = (fsm == ST_LOCKED) && (cnt == CW'(TIMEOUT));

  // Counts owner-idle cycles only; a full stall with a valid owner holds it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (fsm == ST_IDLE || xfer || fire) begin
      cnt <= '0;
    end else if (!in_valid[owner]) begin
      cnt <= cnt + 1'b1;
    end
  end
`else
  assign fire = 1'b0;
`endif

  // While locked only the owner may transfer; otherwise the picker decides.
  always_comb begin
    sel      = (fsm == ST_LOCKED) ? owner : gnt_idx;
    can      = (fsm == ST_LOCKED) ? in_valid[owner] : (|gnt);
    xfer     = can && !full && !fire;
    in_read  = xfer ? (NPORTS'(1) << sel) : '0;
    write    = xfer;
    item_out = xfer ? in_item[int'(sel)*SIZE +: SIZE] : '0;
  end

  assign locked      = (fsm == ST_LOCKED);
  assign err_timeout = fire;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fsm   <= ST_IDLE;
      ptr   <= P_L;
      owner <= P_N;
    end else begin
      case (fsm)
        ST_IDLE: begin
          if (xfer) begin
            if (in_tail[sel]) begin
              ptr <= sel;
            end else begin
              fsm   <= ST_LOCKED;
              owner <= sel;
            end
          end
        end
        default: begin
          if (fire || (xfer && in_tail[owner])) begin
            fsm <= ST_IDLE;
            ptr <= owner;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rx_arbiter.sv
// Directed bench for rx_arbiter: each step queues the expected outputs,
// which are popped and checked against the DUT at the falling clock edge.
module tb_rx_arbiter;

  localparam int SIZE = 8;
  localparam int NP   = 5;

  logic              clk;
  logic              reset;
  logic [NP-1:0]     in_valid;
  logic [NP-1:0]     in_tail;
  logic [NP*SIZE-1:0] in_item;
  logic [NP-1:0]     in_read;
  logic              full;
  logic              write;
  logic [SIZE-1:0]   item_out;
  logic              locked;
  logic              err_timeout;

  typedef struct {
    string           tag;
    logic [NP-1:0]   read;
    logic            wr;
    logic [SIZE-1:0] item;
    logic            lck;
    logic            err;
  } exp_t;

  exp_t           sb[$];
  logic [SIZE-1:0] items [NP];
  int passed;
  int total;

  rx_arbiter #(.SIZE(SIZE), .TIMEOUT(16)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_tail     (in_tail),
    .in_item     (in_item),
    .in_read     (in_read),
    .full        (full),
    .write       (write),
    .item_out    (item_out),
    .locked      (locked),
    .err_timeout (err_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check1(input string tag, input logic [SIZE-1:0] obs, input logic [SIZE-1:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("[TB] FAIL %s: got %h, expected %h", tag, obs, exp);
  endtask

  // Drives one cycle of stimulus, queues its expectation, checks at negedge.
  task automatic applyStimulus(input string tag, input logic [NP-1:0] v, input logic [NP-1:0] t,
                               input logic f, input logic [NP-1:0] exp_read,
                               input logic exp_lck, input logic exp_err);
    exp_t e;
    in_valid = v;
    in_tail  = t;
    full     = f;
    for (int i = 0; i < NP; i++) begin
      items[i] = SIZE'($urandom_range(0, 255));
      in_item[i*SIZE +: SIZE] = items[i];
    end
    e.tag  = tag;
    e.read = exp_read;
    e.wr   = |exp_read;
    e.item = '0;
    for (int i = 0; i < NP; i++) if (exp_read[i]) e.item = items[i];
    e.lck  = exp_lck;
    e.err  = exp_err;
    sb.push_back(e);
    @(negedge clk);
    checkOutput();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput();
    exp_t e;
    if (sb.size() == 0) begin
      total++;
      $error("[TB] FAIL scoreboard: got empty queue, expected an entry");
      return;
    end
    e = sb.pop_front();
    check1({e.tag, ".in_read"}, SIZE'(in_read), SIZE'(e.read));
    check1({e.tag, ".write"}, SIZE'(write), SIZE'(e.wr));
    check1({e.tag, ".item_out"}, item_out, e.item);
    check1({e.tag, ".locked"}, SIZE'(locked), SIZE'(e.lck));
    check1({e.tag, ".err_timeout"}, SIZE'(err_timeout), SIZE'(e.err));
  endtask

  initial begin
    passed   = 0;
    total    = 0;
    reset    = 1'b1;
    in_valid = '0;
    in_tail  = '0;
    in_item  = '0;
    full     = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    applyStimulus("reset", 5'b00000, 5'b00000, 1'b0, 5'b00000, 1'b0, 1'b0);
    reset = 1'b0;

    // Round robin over single-flit packets starting from N
    applyStimulus("rr_n", 5'b11111, 5'b11111, 1'b0, 5'b00001, 1'b0, 1'b0);
    applyStimulus("rr_s", 5'b11111, 5'b11111, 1'b0, 5'b00010, 1'b0, 1'b0);
    applyStimulus("rr_e", 5'b11111, 5'b11111, 1'b0, 5'b00100, 1'b0, 1'b0);
    applyStimulus("rr_w", 5'b11111, 5'b11111, 1'b0, 5'b01000, 1'b0, 1'b0);
    applyStimulus("rr_l", 5'b11111, 5'b11111, 1'b0, 5'b10000, 1'b0, 1'b0);
    applyStimulus("rr_n2", 5'b11111, 5'b11111, 1'b0, 5'b00001, 1'b0, 1'b0);

    // S holds the lock for a 3-flit packet while N and E wait
    applyStimulus("lock_s1", 5'b00111, 5'b00000, 1'b0, 5'b00010, 1'b0, 1'b0);
    applyStimulus("lock_s2", 5'b00111, 5'b00000, 1'b0, 5'b00010, 1'b1, 1'b0);
    applyStimulus("lock_s3", 5'b00111, 5'b00010, 1'b0, 5'b00010, 1'b1, 1'b0);
    applyStimulus("after_e", 5'b00101, 5'b11111, 1'b0, 5'b00100, 1'b0, 1'b0);

    // Back-pressure in the middle of a W packet
    applyStimulus("bp_w1", 5'b01000, 5'b00000, 1'b0, 5'b01000, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++)
      applyStimulus("bp_full", 5'b11111, 5'b00000, 1'b1, 5'b00000, 1'b1, 1'b0);
    applyStimulus("bp_w2", 5'b01000, 5'b00000, 1'b0, 5'b01000, 1'b1, 1'b0);
    applyStimulus("bp_w3", 5'b01000, 5'b01000, 1'b0, 5'b01000, 1'b1, 1'b0);
    applyStimulus("bp_ptr", 5'b11111, 5'b11111, 1'b0, 5'b10000, 1'b0, 1'b0);

    // Owner N goes quiet mid-packet; W must not sneak in
    applyStimulus("gap_n1", 5'b00001, 5'b00000, 1'b0, 5'b00001, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++)
      applyStimulus("gap_w", 5'b01000, 5'b00000, 1'b0, 5'b00000, 1'b1, 1'b0);
    applyStimulus("gap_n2", 5'b01001, 5'b00001, 1'b0, 5'b00001, 1'b1, 1'b0);
    applyStimulus("gap_w2", 5'b01000, 5'b11111, 1'b0, 5'b01000, 1'b0, 1'b0);

    // Asynchronous reset between edges while S owns the FIFO
    applyStimulus("rst_s1", 5'b00010, 5'b00000, 1'b0, 5'b00010, 1'b0, 1'b0);
    in_valid = '0;
    #1 reset = 1'b1;
    #1 check1("rst_async.locked", SIZE'(locked), SIZE'(1'b0));
    #1 reset = 1'b0;
    applyStimulus("rst_n", 5'b11111, 5'b11111, 1'b0, 5'b00001, 1'b0, 1'b0);

    // E locks then idles for 20 cycles
    applyStimulus("to_e1", 5'b00100, 5'b00000, 1'b0, 5'b00100, 1'b0, 1'b0);
`ifdef RX_ARB_TIMEOUT_EN
    for (int i = 1; i <= 20; i++)
      applyStimulus("to_idle", 5'b00000, 5'b00000, 1'b0, 5'b00000,
                    (i <= 17) ? 1'b1 : 1'b0, (i == 17) ? 1'b1 : 1'b0);
    applyStimulus("to_next", 5'b11111, 5'b11111, 1'b0, 5'b01000, 1'b0, 1'b0);
`else
    for (int i = 1; i <= 20; i++)
      applyStimulus("to_hold", 5'b00000, 5'b00000, 1'b0, 5'b00000, 1'b1, 1'b0);
    applyStimulus("to_e2", 5'b11111, 5'b11111, 1'b0, 5'b00100, 1'b1, 1'b0);
    applyStimulus("to_next", 5'b11111, 5'b11111, 1'b0, 5'b01000, 1'b0, 1'b0);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $fatal(1, "[TB] FAIL watchdog: got no finish, expected completion");
  end

endmodule
